// File: rtl/apple_manager.sv
// apple_manager: owns the single apple on the snake grid and pulses eat_apple when the head reaches it
//   clk, reset       clock and asynchronous active-high reset
//   tick             game-step strobe; head_x/head_y are valid while it is high
//   head_x, head_y   snake head position
//   query_x/query_y  candidate cell shown to the occupancy map (combinational)
//   query_occupied   occupancy map answer for the candidate, same cycle
//   apple_x/apple_y  current apple position, apple_valid while it is placed
//   eat_apple        one-cycle pulse to the score tracker
//   no_space         sticky flag: no free cell left on the board
module apple_manager #(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int MAX_TRIES = 16,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  output logic [XW-1:0] query_x,
  output logic [YW-1:0] query_y,
  input  logic          query_occupied,
  output logic [XW-1:0] apple_x,
  output logic [YW-1:0] apple_y,
  output logic          apple_valid,
  output logic          eat_apple,
  output logic          no_space
);
  localparam int CW = XW + YW;
  localparam logic [15:0] S0 = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [CW-1:0] LAST = CW'(GRID_W * GRID_H - 1);
  typedef enum logic [1:0] {PLACE, SCAN, ACTIVE, FULL} state_t;
  state_t state;
  logic [15:0] lfsr, lfsr_next;
  logic [7:0] tries;
  logic [CW-1:0] scan_idx, cand;
  // With power-of-two grids, raster index and LFSR bits split into (y, x) the same way.
  always_comb begin
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    cand = (state == SCAN) ? scan_idx : lfsr[CW-1:0];
  end
  assign query_x = cand[XW-1:0];
  assign query_y = cand[CW-1:XW];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PLACE;
      lfsr <= S0;
      tries <= '0;
      scan_idx <= '0;
      apple_x <= '0;
      apple_y <= '0;
      apple_valid <= 1'b0;
      eat_apple <= 1'b0;
      no_space <= 1'b0;
    end else begin
      eat_apple <= 1'b0;
      case (state)
        PLACE:
          if (!query_occupied) begin
            apple_x <= query_x;
            apple_y <= query_y;
            apple_valid <= 1'b1;
            tries <= '0;
            state <= ACTIVE;
          end else begin
            lfsr <= lfsr_next;
            tries <= tries + 8'd1;
            if (tries == 8'(MAX_TRIES - 1)) begin
              scan_idx <= '0;
              state <= SCAN;
            end
          end
        SCAN:
          if (!query_occupied) begin
            apple_x <= query_x;
            apple_y <= query_y;
            apple_valid <= 1'b1;
            tries <= '0;
            state <= ACTIVE;
          end else if (scan_idx == LAST) begin
            no_space <= 1'b1;
            state <= FULL;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        ACTIVE: begin
          // Free-running here so placement depends on player timing.
          lfsr <= lfsr_next;
          if (tick && head_x == apple_x && head_y == apple_y) begin
            eat_apple <= 1'b1;
            apple_valid <= 1'b0;
            state <= PLACE;
          end
        end
        default: begin
          apple_valid <= 1'b0;
          no_space <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apple_manager.sv
// tb_apple_manager: directed self-checking bench for apple_manager
module tb_apple_manager;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [2:0] head_x = '0, head_y = '0;
  logic [2:0] query_x, query_y, apple_x, apple_y;
  logic query_occupied, apple_valid, eat_apple, no_space;
  int occ_mode = 0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  // 0: empty board, 1: full board, 2: only (7,7) free, 3: only (4,3) free
  always_comb
    query_occupied = (occ_mode == 0) ? 1'b0 :
                     (occ_mode == 1) ? 1'b1 :
                     (occ_mode == 2) ? !(query_x == 3'd7 && query_y == 3'd7) :
                                       !(query_x == 3'd4 && query_y == 3'd3);
  apple_manager dut (
    .clk(clk), .reset(reset), .tick(tick), .head_x(head_x), .head_y(head_y),
    .query_x(query_x), .query_y(query_y), .query_occupied(query_occupied),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .eat_apple(eat_apple), .no_space(no_space)
  );
  task automatic do_reset();
    tick = 1'b0;
    head_x = '0;
    head_y = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_placed(output int n, output int eats);
    n = 0;
    eats = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (eat_apple) eats++;
      if (apple_valid || no_space) break;
    end
  endtask
  task automatic test_reset();
    occ_mode = 0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({apple_valid, eat_apple, no_space, apple_x, apple_y} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000000", {apple_valid, eat_apple, no_space, apple_x, apple_y});
    end
    checks++;
    if ({query_x, query_y} !== {3'd1, 3'd4}) begin
      errors++;
      $display("FAIL reset_query: got (%0d,%0d) required (1,4)", query_x, query_y);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({apple_valid, eat_apple, no_space, apple_x, apple_y} !== {3'b100, 3'd1, 3'd4}) begin
      errors++;
      $display("FAIL first_apple: got v=%b e=%b ns=%b (%0d,%0d) required v=1 e=0 ns=0 (1,4)",
               apple_valid, eat_apple, no_space, apple_x, apple_y);
    end
  endtask
  task automatic test_lfsr_retry();
    int n, eats;
    occ_mode = 3;
    do_reset();
    wait_placed(n, eats);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL retry_latency: got %0d required 4", n);
    end
    checks++;
    if ({apple_valid, apple_x, apple_y} !== {1'b1, 3'd4, 3'd3}) begin
      errors++;
      $display("FAIL retry_apple: got v=%b (%0d,%0d) required v=1 (4,3)", apple_valid, apple_x, apple_y);
    end
  endtask
  task automatic test_miss();
    int bad = 0;
    occ_mode = 0;
    do_reset();
    @(posedge clk);
    head_x = 3'd2;
    head_y = 3'd4;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tick = (i % 3 == 0);
      if (eat_apple || !apple_valid || apple_x != 3'd1 || apple_y != 3'd4) bad++;
    end
    tick = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL miss_no_change: got %0d bad cycles required 0", bad);
    end
  endtask
  task automatic test_eat();
    occ_mode = 0;
    do_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    head_x = 3'd1;
    head_y = 3'd4;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if ({eat_apple, apple_valid} !== 2'b10) begin
      errors++;
      $display("FAIL eat_pulse: got e=%b v=%b required e=1 v=0", eat_apple, apple_valid);
    end
    @(negedge clk);
    checks++;
    if ({eat_apple, apple_valid, apple_x, apple_y} !== {2'b01, 3'd0, 3'd6}) begin
      errors++;
      $display("FAIL eat_replace: got e=%b v=%b (%0d,%0d) required e=0 v=1 (0,6)",
               eat_apple, apple_valid, apple_x, apple_y);
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] seen;
    occ_mode = 0;
    do_reset();
    @(negedge clk);
    head_x = 3'd1;
    head_y = 3'd4;
    tick = 1'b1;
    @(negedge clk);
    seen[2] = eat_apple;
    head_x = 3'd0;
    head_y = 3'd6;
    @(negedge clk);
    seen[1] = eat_apple;
    @(negedge clk);
    seen[0] = eat_apple;
    tick = 1'b0;
    checks++;
    if (seen !== 3'b101) begin
      errors++;
      $display("FAIL back_to_back: got %b required 101", seen);
    end
  endtask
  task automatic test_scan();
    int n, eats;
    occ_mode = 2;
    do_reset();
    wait_placed(n, eats);
    checks++;
    if (n !== 80) begin
      errors++;
      $display("FAIL scan_latency: got %0d required 80", n);
    end
    checks++;
    if ({apple_valid, no_space, apple_x, apple_y} !== {2'b10, 3'd7, 3'd7}) begin
      errors++;
      $display("FAIL scan_apple: got v=%b ns=%b (%0d,%0d) required v=1 ns=0 (7,7)",
               apple_valid, no_space, apple_x, apple_y);
    end
  endtask
  task automatic test_full();
    int n, eats, bad = 0;
    occ_mode = 1;
    do_reset();
    tick = 1'b1;
    wait_placed(n, eats);
    checks++;
    if (n !== 80) begin
      errors++;
      $display("FAIL full_latency: got %0d required 80", n);
    end
    checks++;
    if ({no_space, apple_valid, eats != 0} !== 3'b100) begin
      errors++;
      $display("FAIL full_flags: got ns=%b v=%b eats=%0d required ns=1 v=0 eats=0", no_space, apple_valid, eats);
    end
    occ_mode = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!no_space || apple_valid || eat_apple) bad++;
    end
    tick = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_sticky: got %0d bad cycles required 0", bad);
    end
  endtask
  task automatic test_reset_mid();
    int eats = 0;
    occ_mode = 2;
    do_reset();
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({apple_valid, no_space, eat_apple, query_x, query_y} !== {3'b000, 3'd1, 3'd4}) begin
      errors++;
      $display("FAIL reset_in_scan: got v=%b ns=%b e=%b q=(%0d,%0d) required 0 0 0 (1,4)",
               apple_valid, no_space, eat_apple, query_x, query_y);
    end
    occ_mode = 0;
    do_reset();
    @(negedge clk);
    head_x = 3'd1;
    head_y = 3'd4;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    checks++;
    if (eat_apple !== 1'b1) begin
      errors++;
      $display("FAIL eat_before_reset: got %b required 1", eat_apple);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({eat_apple, apple_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_drops_eat: got e=%b v=%b required 0 0", eat_apple, apple_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (eat_apple) eats++;
    end
    checks++;
    if ({eats != 0, apple_valid, apple_x, apple_y} !== {2'b01, 3'd1, 3'd4}) begin
      errors++;
      $display("FAIL restart_from_seed: got eats=%0d v=%b (%0d,%0d) required eats=0 v=1 (1,4)",
               eats, apple_valid, apple_x, apple_y);
    end
  endtask
  initial begin
    test_reset();
    test_lfsr_retry();
    test_miss();
    test_eat();
    test_back_to_back();
    test_scan();
    test_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
